branch_resolve_queue: RTL

- Downstream neighbour of the 2-bit branch predictor.
- Queues each issued prediction (PC and predicted direction) in order.
- When the execute stage resolves the oldest branch, compares the actual direction with the prediction and:
  - emits a training update back to the predictor,
  - flags a mispredict and flushes all younger queued predictions,
  - maintains hit/miss statistics.

---
 rtl/branch_resolve_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of branch predictions, resolved oldest-first,
// producing predictor training updates, mispredict flushes and hit/miss statistics.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  input  logic [PC_W-1:0]            pred_pc,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       upd_valid,
  output logic [PC_W-1:0]            upd_pc,
  output logic                       upd_taken,
  output logic                       mispredict,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           cnt_total,
  output logic [CNT_W-1:0]           cnt_miss,
  output logic                       err_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   mem_pc [DEPTH];
  logic              mem_taken [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic              mispred_q, mispred_d, err_q, err_d;
  logic [PC_W-1:0]   upd_pc_q, upd_pc_d;
  logic [CNT_W-1:0]  total_q, total_d, miss_q, miss_d;
  logic              push, pop, miss, underflow;

  assign pred_ready = (state_q == RUN) && (occ_q != OW'(DEPTH));
  assign push       = pred_valid && pred_ready;
  assign pop        = (state_q == RUN) && res_valid && (occ_q != '0);
  assign miss       = pop && (res_taken != mem_taken[rd_q]);
  assign underflow  = (state_q == RUN) && res_valid && (occ_q == '0);

  // A mispredict discards the whole queue, including a push accepted in the same cycle.
  always_comb begin
    state_d     = miss ? FLUSH : RUN;
    wr_d        = miss ? '0 : (push ? wr_q + AW'(1) : wr_q);
    rd_d        = miss ? '0 : (pop ? rd_q + AW'(1) : rd_q);
    occ_d       = miss ? '0 : occ_q + OW'(push) - OW'(pop);
    upd_valid_d = pop;
    mispred_d   = miss;
    upd_pc_d    = pop ? mem_pc[rd_q] : upd_pc_q;
    upd_taken_d = pop ? res_taken : upd_taken_q;
    total_d     = (pop && !(&total_q)) ? total_q + CNT_W'(1) : total_q;
    miss_d      = (miss && !(&miss_q)) ? miss_q + CNT_W'(1) : miss_q;
    err_d       = err_q || underflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wr_q        <= '0;
      rd_q        <= '0;
      occ_q       <= '0;
      upd_valid_q <= 1'b0;
      mispred_q   <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      total_q     <= '0;
      miss_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      occ_q       <= occ_d;
      upd_valid_q <= upd_valid_d;
      mispred_q   <= mispred_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
      total_q     <= total_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_q]    <= pred_pc;
      mem_taken[wr_q] <= pred_taken;
    end
  end

  assign upd_valid     = upd_valid_q;
  assign upd_pc        = upd_pc_q;
  assign upd_taken     = upd_taken_q;
  assign mispredict    = mispred_q;
  assign occupancy     = occ_q;
  assign cnt_total     = total_q;
  assign cnt_miss      = miss_q;
  assign err_underflow = err_q;
endmodule
